// File: rtl/sensor_level_encoder_pkg.sv
// Shared types, default thresholds and the quantizer for the sensor level front-end.
package sensor_pkg;
  typedef enum logic [1:0] {CH_RAIN = 2'd0, CH_SEIS = 2'd1, CH_WIND = 2'd2, CH_LEVEL = 2'd3} channel_e;
  typedef logic [1:0] level_t;

  localparam int NUM_CH       = 4;
  localparam int DEF_T1       = 64;
  localparam int DEF_T2       = 128;
  localparam int DEF_T3       = 192;
  localparam int DEF_HYST     = 4;
  localparam int DEF_DEBOUNCE = 3;

  function automatic int sat_sub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  // A sample equal to a threshold belongs to the upper level.
  function automatic level_t quantize(input int x, input int t1, input int t2, input int t3);
    if (x < t1)      return 2'd0;
    else if (x < t2) return 2'd1;
    else if (x < t3) return 2'd2;
    else             return 2'd3;
  endfunction
endpackage

// File: rtl/sensor_level_encoder_channel_debounce.sv
// One channel's committed level plus its pending-candidate debounce counter.
module channel_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  level_t k,
  output level_t c,
  output logic   commit
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  level_t           c_q, c_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;

  always_comb begin
    c_d     = c_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    cnt_nxt = cnt_q;
    commit  = 1'b0;
    if (en) begin
      if (k == c_q) begin
        cnt_d = '0;
      end else begin
        // A run only continues if it is already live for the same candidate.
        if (k == pend_q && cnt_q != '0) begin
          cnt_nxt = cnt_q + 1'b1;
        end else begin
          pend_d  = k;
          cnt_nxt = CNT_W'(1);
        end
        if (cnt_nxt == CNT_W'(DEBOUNCE)) begin
          c_d    = k;
          cnt_d  = '0;
          commit = 1'b1;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      c_q    <= c_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign c = c_q;
endmodule

// File: rtl/sensor_level_encoder.sv
// Quantizes raw per-channel samples with hysteresis and debounces them into 2-bit severity levels.
module sensor_level_encoder
  import sensor_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int T1       = DEF_T1,
  parameter int T2       = DEF_T2,
  parameter int T3       = DEF_T3,
  parameter int HYST     = DEF_HYST,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  output logic              r1, r0, s1, s0, w1, w0, l1, l0,
  output logic              changed,
  output logic [1:0]        changed_ch
);
  localparam int D1 = sat_sub(T1, HYST);
  localparam int D2 = sat_sub(T2, HYST);
  localparam int D3 = sat_sub(T3, HYST);

  logic              s_valid_q, s_valid_d;
  logic [1:0]        s_ch_q, s_ch_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              changed_q, changed_d;
  logic [1:0]        changed_ch_q, changed_ch_d;

  logic [NUM_CH-1:0][1:0] lvl;
  logic [NUM_CH-1:0]      commit;
  level_t                 u, d, c_sel, k;

  assign in_ready = ~hold;

  always_comb begin
    s_valid_d = in_valid & in_ready;
    s_ch_d    = s_valid_d ? in_ch : s_ch_q;
    s_data_d  = s_valid_d ? in_data : s_data_q;
  end

  // Upward moves use the nominal thresholds, downward moves the lowered ones.
  always_comb begin
    u     = quantize(int'(s_data_q), T1, T2, T3);
    d     = quantize(int'(s_data_q), D1, D2, D3);
    c_sel = lvl[s_ch_q];
    if (u > c_sel)      k = u;
    else if (d < c_sel) k = d;
    else                k = c_sel;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (s_valid_q && (s_ch_q == 2'(i))),
      .k      (k),
      .c      (lvl[i]),
      .commit (commit[i])
    );
  end

  always_comb begin
    changed_d    = |commit;
    changed_ch_d = (|commit) ? s_ch_q : changed_ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q    <= 1'b0;
      s_ch_q       <= '0;
      s_data_q     <= '0;
      changed_q    <= 1'b0;
      changed_ch_q <= '0;
    end else begin
      s_valid_q    <= s_valid_d;
      s_ch_q       <= s_ch_d;
      s_data_q     <= s_data_d;
      changed_q    <= changed_d;
      changed_ch_q <= changed_ch_d;
    end
  end

  assign {r1, r0}   = lvl[CH_RAIN];
  assign {s1, s0}   = lvl[CH_SEIS];
  assign {w1, w0}   = lvl[CH_WIND];
  assign {l1, l0}   = lvl[CH_LEVEL];
  assign changed    = changed_q;
  assign changed_ch = changed_ch_q;
endmodule

// File: doc/sensor_level_encoder.md
# sensor_level_encoder

Front-end that turns raw 8-bit sensor samples into the 2-bit severity levels (r1:r0 rain, s1:s0 seismic, w1:w0 wind, l1:l0 water level) consumed by the disaster detector. Samples arrive one channel at a time over a valid/ready handshake. Each sample is quantized against three thresholds with hysteresis, then debounced per channel. Committed levels are held in registers that drive the detector inputs directly.

## Interface
- DATA_W, 8: raw sample width
- T1, 64: level 0/1 threshold
- T2, 128: level 1/2 threshold
- T3, 192: level 2/3 threshold
- HYST, 4: downward hysteresis margin, in LSBs
- DEBOUNCE, 3: consecutive agreeing samples required to change a level (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_ch  in  2  channel: 0 rain, 1 seismic, 2 wind, 3 level
- in_data  in  DATA_W  raw sample, unsigned
- hold  in  1  freeze acceptance of new samples
- r1, r0, s1, s0, w1, w0, l1, l0  out  1 each  committed levels, registered
- changed  out  1  one-cycle pulse when any level commits a new value
- changed_ch  out  2  channel of last commit, valid while changed=1

## Operation
- in_ready = ~hold. Transfer occurs when in_valid & in_ready at a rising edge.
- Stage 1 registers the accepted sample: s_valid, s_ch, s_data.
- Stage 2 processes a valid stage-1 sample against channel s_ch, with committed level c:
  - u = quantize(s_data; T1, T2, T3)
  - d = quantize(s_data; T1−HYST, T2−HYST, T3−HYST). Subtraction saturates at 0.
  - quantize gives 0 below the first threshold, 1 below the second, 2 below the third, otherwise 3. A value equal to a threshold goes up.
  - Candidate k = u if u > c; else d if d < c; else c.
- Per-channel debounce state: pend (2 bits), cnt (0..DEBOUNCE), updated in stage 2:
  - k == c: cnt ← 0.
  - k ≠ c and k == pend and cnt ≥ 1: cnt ← cnt+1.
  - k ≠ c otherwise: pend ← k, cnt ← 1.
  - If the resulting cnt == DEBOUNCE: c ← k, cnt ← 0, changed ← 1, changed_ch ← s_ch.
- DEBOUNCE = 1 means the level commits on the first qualifying sample.
- Levels may jump by more than one step (for example 0 → 3) in a single commit.
- A channel not addressed in a cycle keeps its state unchanged.

## Timing
- Reset values: all level outputs 0, changed 0, changed_ch 0, all pend/cnt 0, s_valid 0. in_ready follows hold combinationally.
- Latency: sample accepted at edge N → stage 2 update at edge N+1. A new level and the changed pulse are visible after edge N+1 and last one cycle.
- Throughput: one sample per cycle while hold = 0. No bubbles.
- hold blocks new acceptance only. A sample already in stage 1 still completes.
- Reset asserted mid-operation: the in-flight sample is dropped and all state returns to reset values immediately (asynchronous). On deassertion, acceptance resumes at the first edge where hold = 0.
- Only one channel is updated per cycle, so simultaneous commits cannot occur.
- changed is not raised when k == c.

## Structure
- Package sensor_pkg holds:
  - channel enum (CH_RAIN, CH_SEIS, CH_WIND, CH_LEVEL)
  - level_t (2-bit) typedef
  - default threshold constants
  - a quantize function
- Sub-module channel_debounce holds pend/cnt/c and commit logic for one channel. It is instantiated four times, each enabled by stage-2 valid & (s_ch == index).
- Top level holds the handshake, the stage-1 register, candidate computation and output mapping.

## Test plan
- Reset: drive rst_n = 0 with traffic present → all levels 0, changed 0. After release with hold = 0, in_ready = 1.
- Rain samples 200, 200, 200 on consecutive cycles → r1:r0 = 11 after the third sample's edge+1, with a single changed pulse and changed_ch = 0. No change after the first two samples.
- Hysteresis: rain committed at 3. Send 190 ×3 → stays 3, no pulse. Then 180 ×3 → level 2.
- Broken run: wind samples 200, 200, 10, 200, 200 → no commit. A following sixth sample of 200 commits w1:w0 = 11.
- Interleave: seismic 130 and water 250 alternating ×3 each → s1:s0 = 10, then l1:l0 = 11. Rain and wind stay 0.
- Hold and mid-reset:
  - hold = 1 with in_valid high → in_ready = 0, no state change.
  - Pulse rst_n low after two of three level-3 samples → level stays 0. Three fresh samples are needed to commit.
